mux8_scan_ctrl: RTL

- Upstream sequencer for the team's 8:1 behavioural mux.
- On a start pulse it loads an 8-bit word onto the mux data inputs i1..i8, then steps the selects {s0,s1,s2} through 0..7.
- It samples the mux output o for each select value, emits each sample as a serial bit, and rebuilds the captured word.
- At the end it flags any difference between the captured word and the loaded word. It serves as a parallel-to-serial front end and as a built-in self-check of the mux.

---
 rtl/mux8_scan_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/mux8_scan_ctrl.sv
// Loads a word onto an 8:1 mux, steps selects 0..7, serialises each sampled output and rebuilds the word.
// Start to IDLE takes 8*DWELL+1 cycles; start is ignored while busy or in the DONE cycle.
module mux8_scan_ctrl #(
   parameter int DWELL = 1,
   parameter int CW    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] data_in,
   input  logic       o,
   output logic       s0,
   output logic       s1,
   output logic       s2,
   output logic       i1,
   output logic       i2,
   output logic       i3,
   output logic       i4,
   output logic       i5,
   output logic       i6,
   output logic       i7,
   output logic       i8,
   output logic       busy,
   output logic       ser_bit,
   output logic       ser_valid,
   output logic [7:0] cap_data,
   output logic       done,
   output logic       mismatch
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [CW-1:0] DWELL_M1 = CW'(DWELL - 1);

   logic [1:0]    r_state;
   logic [2:0]    r_index;
   logic [CW-1:0] r_dwell;
   logic [7:0]    r_load;
   logic [7:0]    r_cap;
   logic          r_busy;
   logic          r_ser_bit;
   logic          r_ser_vld;
   logic          r_done;
   logic          r_mis;

   logic          w_last;
   logic [7:0]    w_cap_nxt;

   assign w_last = (r_dwell == DWELL_M1);

   // Captured word including the bit sampled this cycle, so the final compare sees bit 7.
   always_comb begin
      w_cap_nxt          = r_cap;
      w_cap_nxt[r_index] = o;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_index   <= 3'd0;
         r_dwell   <= '0;
         r_load    <= 8'd0;
         r_cap     <= 8'd0;
         r_busy    <= 1'b0;
         r_ser_bit <= 1'b0;
         r_ser_vld <= 1'b0;
         r_done    <= 1'b0;
         r_mis     <= 1'b0;
      end else begin
         r_ser_vld <= 1'b0;
         r_done    <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_load  <= data_in;
                  r_index <= 3'd0;
                  r_dwell <= '0;
                  r_cap   <= 8'd0;
                  r_mis   <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (w_last) begin
                  r_dwell   <= '0;
                  r_cap     <= w_cap_nxt;
                  r_ser_bit <= o;
                  r_ser_vld <= 1'b1;
                  if (r_index == 3'd7) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_mis   <= (w_cap_nxt != r_load);
                  end else begin
                     r_index <= r_index + 3'd1;
                  end
               end else begin
                  r_dwell <= r_dwell + CW'(1);
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign {s0, s1, s2} = r_index;
   assign {i8, i7, i6, i5, i4, i3, i2, i1} = r_load;
   assign busy      = r_busy;
   assign ser_bit   = r_ser_bit;
   assign ser_valid = r_ser_vld;
   assign cap_data  = r_cap;
   assign done      = r_done;
   assign mismatch  = r_mis;

endmodule
